// File: rtl/dpram_port_master.sv
// dpram_port_master
//   Initiator for one port of a dual-port block RAM (ce/we/addr/write/read).
//   A fill command writes seed+k to base+k for k = 0..len. A check command
//   reads the same range back and counts words that differ from seed+k.
//   One RAM access per clock. Addresses wrap modulo 2**ADDR_W.
//
// Ports
//   clk, rst_n              clock (rising edge), asynchronous active-low reset
//   cmd_valid/cmd_ready     command handshake (ready only while idle)
//   cmd_write               1 = fill, 0 = check
//   cmd_base/len/seed       first address, access count - 1, pattern start
//   abort                   cancel the running command (ignored while idle)
//   mem_ce/we/addr/write    RAM port outputs (all registered)
//   mem_read                RAM read data, valid RD_LAT clocks after mem_ce
//   busy                    command running or draining reads
//   done                    one-cycle pulse on normal completion
//   err_count               saturating mismatch count of the last check
//
// Optional feature: define ERR_CAPTURE_EN to add err_addr/err_data, which
// capture the address and read value of the first mismatch of a check.

module dpram_port_master #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 16,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_base,
  input  logic [ADDR_W-1:0] cmd_len,
  input  logic [DATA_W-1:0] cmd_seed,
  input  logic              abort,
  output logic              mem_ce,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_write,
  input  logic [DATA_W-1:0] mem_read,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W:0]   err_count
`ifdef ERR_CAPTURE_EN
  ,
  output logic [ADDR_W-1:0] err_addr,
  output logic [DATA_W-1:0] err_data
`endif
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t              state_q;
  logic                cmd_ready_q, busy_q, done_q;
  logic                mem_ce_q, mem_we_q;
  logic [ADDR_W-1:0]   mem_addr_q, len_q, cnt_q;
  logic [DATA_W-1:0]   mem_write_q;
  logic                wr_q;
  logic [2:0]          dcnt_q;

  logic                accept, flush, rd_issue, cmp_hit;
  logic [RD_LAT:1]               vld_pipe_q;
  logic [RD_LAT:1][DATA_W-1:0]   exp_pipe_q;
  logic [ADDR_W:0]     err_q;

  assign accept   = (state_q == S_IDLE) && cmd_valid;
  // abort wins over everything except an accept in the same cycle
  assign flush    = abort && (state_q != S_IDLE);
  // mem_write_q carries seed+k on reads too, so it doubles as the expected value
  assign rd_issue = mem_ce_q && !mem_we_q;
  assign cmp_hit  = vld_pipe_q[RD_LAT] && (mem_read != exp_pipe_q[RD_LAT]);

  // Control FSM with registered RAM-port and status outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cmd_ready_q <= 1'b1;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      mem_ce_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_write_q <= '0;
      wr_q        <= 1'b0;
      len_q       <= '0;
      cnt_q       <= '0;
      dcnt_q      <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: if (cmd_valid) begin
          state_q     <= S_RUN;
          cmd_ready_q <= 1'b0;
          busy_q      <= 1'b1;
          wr_q        <= cmd_write;
          len_q       <= cmd_len;
          cnt_q       <= '0;
          mem_ce_q    <= 1'b1;
          mem_we_q    <= cmd_write;
          mem_addr_q  <= cmd_base;
          mem_write_q <= cmd_seed;
        end
        S_RUN: begin
          if (cnt_q == len_q) begin
            mem_ce_q <= 1'b0;
            mem_we_q <= 1'b0;
            if (wr_q) begin
              state_q <= S_DONE;
              done_q  <= 1'b1;
              busy_q  <= 1'b0;
            end else begin
              state_q <= S_DRAIN;
              dcnt_q  <= '0;
            end
          end else begin
            cnt_q       <= cnt_q + ADDR_W'(1);
            mem_addr_q  <= mem_addr_q + ADDR_W'(1);
            mem_write_q <= mem_write_q + DATA_W'(1);
          end
        end
        // wait for the last read to come back and be compared
        S_DRAIN: begin
          if (dcnt_q == 3'(RD_LAT - 1)) begin
            state_q <= S_DONE;
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
          end else begin
            dcnt_q <= dcnt_q + 3'd1;
          end
        end
        S_DONE: begin
          state_q     <= S_IDLE;
          cmd_ready_q <= 1'b1;
        end
        default: state_q <= S_IDLE;
      endcase
      if (flush) begin
        state_q     <= S_IDLE;
        cmd_ready_q <= 1'b1;
        busy_q      <= 1'b0;
        done_q      <= 1'b0;
        mem_ce_q    <= 1'b0;
        mem_we_q    <= 1'b0;
      end
    end
  end

  // Read-compare pipe: stage i is valid i cycles after the read was issued
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe_q <= '0;
      exp_pipe_q <= '0;
    end else if (flush) begin
      vld_pipe_q <= '0;
    end else begin
      vld_pipe_q[1] <= rd_issue;
      exp_pipe_q[1] <= mem_write_q;
      for (int i = 2; i <= RD_LAT; i++) begin
        vld_pipe_q[i] <= vld_pipe_q[i-1];
        exp_pipe_q[i] <= exp_pipe_q[i-1];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      err_q <= '0;
    else if (accept)
      err_q <= '0;
    else if (cmp_hit && !flush && (err_q != '1))
      err_q <= err_q + (ADDR_W+1)'(1);
  end

`ifdef ERR_CAPTURE_EN
  logic [RD_LAT:1][ADDR_W-1:0] adr_pipe_q;
  logic [ADDR_W-1:0]           err_addr_q;
  logic [DATA_W-1:0]           err_data_q;
  logic                        seen_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      adr_pipe_q <= '0;
      err_addr_q <= '0;
      err_data_q <= '0;
      seen_q     <= 1'b0;
    end else begin
      adr_pipe_q[1] <= mem_addr_q;
      for (int i = 2; i <= RD_LAT; i++) adr_pipe_q[i] <= adr_pipe_q[i-1];
      if (accept) begin
        err_addr_q <= '0;
        err_data_q <= '0;
        seen_q     <= 1'b0;
      end else if (cmp_hit && !flush && !seen_q) begin
        err_addr_q <= adr_pipe_q[RD_LAT];
        err_data_q <= mem_read;
        seen_q     <= 1'b1;
      end
    end
  end

  assign err_addr = err_addr_q;
  assign err_data = err_data_q;
`endif

  assign cmd_ready = cmd_ready_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign mem_ce    = mem_ce_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_write = mem_write_q;
  assign err_count = err_q;

endmodule
